vs_codec_responder: RTL and testbench

//  Responder side of the VS10xx-style SCI/SDI serial link driven by the MP3 player master.

---
 rtl/vs_codec_pkg.sv | 28 ++
 rtl/sdi_byte_fifo.sv | 61 ++++++
 rtl/vs_codec_responder.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_vs_codec_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vs_codec_pkg.sv
// Shared opcodes, register map constants and FSM encodings for the VS10xx-style codec responder.
package vs_codec_pkg;

    localparam logic [7:0] SCI_OP_WRITE  = 8'h02;
    localparam logic [7:0] SCI_OP_READ   = 8'h03;
    localparam logic [3:0] REG_MODE      = 4'h0;
    localparam int         MODE_SM_RESET = 2;

    typedef enum logic [2:0] {
        SCI_IDLE,
        SCI_HDR,
        SCI_WDATA,
        SCI_RDATA,
        SCI_SKIP
    } sci_state_e;

    typedef enum logic [1:0] {
        RST_HARD,
        RST_WAIT,
        RUN
    } rst_state_e;

    // Only addresses 0..15 map onto the register file.
    function automatic logic sci_addr_ok(input logic [7:0] addr);
        return addr[7:4] == 4'h0;
    endfunction

endpackage

// File: rtl/sdi_byte_fifo.sv
// Byte FIFO for the SDI stream with occupancy count and synchronous flush.
module sdi_byte_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign valid_o = count_q != '0;
    assign full_o  = count_q == CW'(DEPTH);
    // A pop on a full FIFO frees the slot the concurrent push lands in.
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vs_codec_responder.sv
// Codec-side SCI/SDI responder: register file over SCI, byte FIFO over SDI, DREQ and reset sequencing.
// rst FSM   | meaning                      sci FSM   | meaning
// RST_HARD  | XRESET low, all state held   SCI_IDLE  | XCS high or not running
// RST_WAIT  | post-reset DREQ hold-off     SCI_HDR   | collecting opcode+address
// RUN       | serial traffic accepted      SCI_WDATA | collecting write data
//                                          SCI_RDATA | shifting read data on SO
//                                          SCI_SKIP  | frame done/unknown, wait XCS
module vs_codec_responder
    import vs_codec_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 64,
    parameter int          DREQ_FREE    = 32,
    parameter int          HRST_CYCLES  = 1000,
    parameter int          SRST_CYCLES  = 200,
    parameter logic [15:0] MODE_DEFAULT = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCK,
    input  logic        SI,
    input  logic        XCS,
    input  logic        XDCS,
    input  logic        XRESET,
    output logic        SO,
    output logic        DREQ,
    output logic [7:0]  sdi_data,
    output logic        sdi_valid,
    input  logic        sdi_ready,
    output logic        reg_wr,
    output logic [3:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        overflow
);

    localparam int RST_MAX   = (HRST_CYCLES > SRST_CYCLES) ? HRST_CYCLES : SRST_CYCLES;
    localparam int RST_CNT_W = $clog2(RST_MAX + 1);
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [4:0] SYNC_RST = 5'b11100;

    // Synchronizers: {XRESET, XDCS, XCS, SI, SCK}
    logic [4:0] meta_q, sync_q;
    logic       sck_prev_q;
    logic       sck_s, si_s, xcs_s, xdcs_s, xreset_s;
    logic       sck_rise, sck_fall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q     <= SYNC_RST;
            sync_q     <= SYNC_RST;
            sck_prev_q <= 1'b0;
        end else begin
            meta_q     <= {XRESET, XDCS, XCS, SI, SCK};
            sync_q     <= meta_q;
            sck_prev_q <= sync_q[0];
        end
    end

    assign {xreset_s, xdcs_s, xcs_s, si_s, sck_s} = sync_q;
    assign sck_rise = sck_s && !sck_prev_q;
    assign sck_fall = !sck_s && sck_prev_q;

    rst_state_e           rst_state_q, rst_state_d;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic                 run;
    logic                 hard_clr;
    logic                 soft_rst;

    sci_state_e  sci_state_q, sci_state_d;
    logic [3:0]  sci_cnt_q, sci_cnt_d;
    logic [14:0] hdr_q, hdr_d;
    logic [7:0]  addr_q, addr_d;
    logic [14:0] wdata_q, wdata_d;
    logic [15:0] rd_sh_q, rd_sh_d;
    logic        so_q, so_d;
    logic        reg_wr_q, reg_wr_d;
    logic [3:0]  reg_addr_q, reg_addr_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic [15:0] hdr_nxt, data_nxt;
    logic        reg_we;
    logic [15:0] reg_we_data;
    logic [15:0] regs_q [16];

    logic [2:0]  sdi_cnt_q, sdi_cnt_d;
    logic [6:0]  sdi_sh_q, sdi_sh_d;
    logic [7:0]  sdi_byte;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_flush;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fifo_free;
    logic        overflow_q;
    logic        dreq_q;

    assign run      = rst_state_q == RUN;
    assign hard_clr = rst_state_q == RST_HARD;

    always_comb begin
        rst_state_d = rst_state_q;
        rst_cnt_d   = rst_cnt_q;
        if (!xreset_s) begin
            rst_state_d = RST_HARD;
        end else begin
            case (rst_state_q)
                RST_HARD: begin
                    rst_state_d = RST_WAIT;
                    rst_cnt_d   = RST_CNT_W'(HRST_CYCLES);
                end
                RST_WAIT: begin
                    if (rst_cnt_q == '0) begin
                        rst_state_d = RUN;
                    end else begin
                        rst_cnt_d = rst_cnt_q - RST_CNT_W'(1);
                    end
                end
                RUN: begin
                    if (soft_rst) begin
                        rst_state_d = RST_WAIT;
                        rst_cnt_d   = RST_CNT_W'(SRST_CYCLES);
                    end
                end
                default: rst_state_d = RST_HARD;
            endcase
        end
    end

    assign hdr_nxt  = {hdr_q, si_s};
    assign data_nxt = {wdata_q, si_s};

    always_comb begin
        sci_state_d = sci_state_q;
        sci_cnt_d   = sci_cnt_q;
        hdr_d       = hdr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_sh_d     = rd_sh_q;
        so_d        = 1'b0;
        reg_wr_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we      = 1'b0;
        reg_we_data = data_nxt;
        soft_rst    = 1'b0;
        if (!run || xcs_s) begin
            sci_state_d = SCI_IDLE;
            sci_cnt_d   = '0;
        end else begin
            case (sci_state_q)
                SCI_IDLE: begin
                    sci_state_d = SCI_HDR;
                    sci_cnt_d   = '0;
                end
                SCI_HDR: begin
                    if (sck_rise) begin
                        hdr_d     = hdr_nxt[14:0];
                        sci_cnt_d = sci_cnt_q + 4'd1;
                        if (sci_cnt_q == 4'd15) begin
                            addr_d = hdr_nxt[7:0];
                            if (hdr_nxt[15:8] == SCI_OP_WRITE) begin
                                sci_state_d = SCI_WDATA;
                            end else if (hdr_nxt[15:8] == SCI_OP_READ) begin
                                sci_state_d = SCI_RDATA;
                                rd_sh_d     = sci_addr_ok(hdr_nxt[7:0]) ? regs_q[hdr_nxt[3:0]] : 16'h0000;
                            end else begin
                                sci_state_d = SCI_SKIP;
                            end
                        end
                    end
                end
                SCI_WDATA: begin
                    if (sck_rise) begin
                        wdata_d   = data_nxt[14:0];
                        sci_cnt_d = sci_cnt_q + 4'd1;
                        if (sci_cnt_q == 4'd15) begin
                            sci_state_d = SCI_SKIP;
                            if (sci_addr_ok(addr_q)) begin
                                // SM_RESET is self-clearing: it never reads back as set.
                                if (addr_q[3:0] == REG_MODE && data_nxt[MODE_SM_RESET]) begin
                                    soft_rst                 = 1'b1;
                                    reg_we_data[MODE_SM_RESET] = 1'b0;
                                end
                                reg_we      = 1'b1;
                                reg_wr_d    = 1'b1;
                                reg_addr_d  = addr_q[3:0];
                                reg_wdata_d = reg_we_data;
                            end
                        end
                    end
                end
                SCI_RDATA: begin
                    so_d = so_q;
                    if (sck_fall) begin
                        so_d    = rd_sh_q[15];
                        rd_sh_d = {rd_sh_q[14:0], 1'b0};
                    end
                    if (sck_rise) begin
                        sci_cnt_d = sci_cnt_q + 4'd1;
                        if (sci_cnt_q == 4'd15) begin
                            sci_state_d = SCI_SKIP;
                            so_d        = 1'b0;
                        end
                    end
                end
                SCI_SKIP: sci_state_d = SCI_SKIP;
                default:  sci_state_d = SCI_IDLE;
            endcase
        end
    end

    // SCI owns the bus whenever XCS is low, even if XDCS is also asserted.
    assign sdi_byte = {sdi_sh_q, si_s};

    always_comb begin
        sdi_cnt_d = sdi_cnt_q;
        sdi_sh_d  = sdi_sh_q;
        fifo_push = 1'b0;
        if (!run || xdcs_s) begin
            sdi_cnt_d = '0;
        end else if (xcs_s && sck_rise) begin
            sdi_sh_d  = sdi_byte[6:0];
            sdi_cnt_d = sdi_cnt_q + 3'd1;
            if (sdi_cnt_q == 3'd7) begin
                fifo_push = 1'b1;
            end
        end
    end

    assign fifo_pop   = sdi_valid && sdi_ready;
    assign fifo_flush = hard_clr || soft_rst;
    assign fifo_free  = CW'(FIFO_DEPTH) - fifo_count;

    sdi_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .data_i  (sdi_byte),
        .pop_i   (fifo_pop),
        .data_o  (sdi_data),
        .valid_o (sdi_valid),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            rst_state_q <= RST_WAIT;
            rst_cnt_q   <= RST_CNT_W'(HRST_CYCLES);
            sci_state_q <= SCI_IDLE;
            sci_cnt_q   <= '0;
            hdr_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_sh_q     <= '0;
            so_q        <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            sdi_cnt_q   <= '0;
            sdi_sh_q    <= '0;
            overflow_q  <= 1'b0;
            dreq_q      <= 1'b0;
        end else begin
            rst_state_q <= rst_state_d;
            rst_cnt_q   <= rst_cnt_d;
            sci_state_q <= sci_state_d;
            sci_cnt_q   <= sci_cnt_d;
            hdr_q       <= hdr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_sh_q     <= rd_sh_d;
            so_q        <= so_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            sdi_cnt_q   <= sdi_cnt_d;
            sdi_sh_q    <= sdi_sh_d;
            if (fifo_flush) begin
                overflow_q <= 1'b0;
            end else if (fifo_push && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
            dreq_q <= run && (fifo_free >= CW'(DREQ_FREE));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || hard_clr) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= (i == 0) ? MODE_DEFAULT : 16'h0000;
            end
        end else if (reg_we) begin
            regs_q[addr_q[3:0]] <= reg_we_data;
        end
    end

    assign SO        = so_q;
    assign DREQ      = dreq_q;
    assign reg_wr    = reg_wr_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_vs_codec_responder.sv
// Closed-loop bench for vs_codec_responder: bit-banged SCI/SDI master with write and byte scoreboards.
module tb_vs_codec_responder;

    localparam int FIFO_DEPTH  = 64;
    localparam int DREQ_FREE   = 32;
    localparam int HRST_CYCLES = 1000;
    localparam int SRST_CYCLES = 200;
    localparam int HALF        = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        SCK = 1'b0;
    logic        SI = 1'b0;
    logic        XCS = 1'b1;
    logic        XDCS = 1'b1;
    logic        XRESET = 1'b1;
    logic        sdi_ready = 1'b0;
    logic        SO, DREQ, sdi_valid, reg_wr, overflow;
    logic [7:0]  sdi_data;
    logic [3:0]  reg_addr;
    logic [15:0] reg_wdata;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_rise = 0;
    logic [31:0] wr_obs[$];
    logic [31:0] wr_exp[$];
    logic [7:0]  byte_exp[$];

    vs_codec_responder #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .DREQ_FREE    (DREQ_FREE),
        .HRST_CYCLES  (HRST_CYCLES),
        .SRST_CYCLES  (SRST_CYCLES),
        .MODE_DEFAULT (16'h0800)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SCK       (SCK),
        .SI        (SI),
        .XCS       (XCS),
        .XDCS      (XDCS),
        .XRESET    (XRESET),
        .SO        (SO),
        .DREQ      (DREQ),
        .sdi_data  (sdi_data),
        .sdi_valid (sdi_valid),
        .sdi_ready (sdi_ready),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && reg_wr) wr_obs.push_back({12'h000, reg_addr, reg_wdata});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic so_s);
        SI = b;
        wait_clk(HALF);
        so_s = SO;
        SCK = 1'b1;
        last_rise = cyc;
        wait_clk(HALF);
        SCK = 1'b0;
    endtask

    task automatic sci_xfer(input logic [31:0] frame, input int nbits, output logic [15:0] rd);
        logic s;
        rd = 16'h0;
        XCS = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(frame[31-i], s);
            if (i >= 16) rd = {rd[14:0], s};
        end
        wait_clk(HALF);
        XCS = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic sci_write(input logic [7:0] addr, input logic [15:0] data);
        logic [15:0] rd;
        if (addr < 8'd16) wr_exp.push_back({12'h000, addr[3:0], data});
        sci_xfer({8'h02, addr, data}, 32, rd);
    endtask

    task automatic sci_read_chk(input string tag, input logic [7:0] addr, input logic [15:0] exp);
        logic [15:0] rd;
        sci_xfer({8'h03, addr, 16'h0000}, 32, rd);
        chk(tag, {16'h0, rd}, {16'h0, exp});
    endtask

    task automatic check_wr(input string tag);
        chk({tag, "_count"}, wr_obs.size(), wr_exp.size());
        while (wr_obs.size() > 0 && wr_exp.size() > 0) chk(tag, wr_obs.pop_front(), wr_exp.pop_front());
        wr_obs.delete();
        wr_exp.delete();
    endtask

    task automatic sdi_byte(input logic [7:0] b, input logic accept);
        logic s;
        for (int i = 7; i >= 0; i--) spi_bit(b[i], s);
        if (accept) byte_exp.push_back(b);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (byte_exp.size() > 0 && guard < 1000) begin
            if (sdi_valid) begin
                chk(tag, {24'h0, sdi_data}, {24'h0, byte_exp.pop_front()});
                sdi_ready = 1'b1;
            end else begin
                sdi_ready = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        sdi_ready = 1'b0;
        if (byte_exp.size() > 0) chk({tag, "_timeout"}, byte_exp.size(), 0);
        byte_exp.delete();
        chk({tag, "_empty"}, sdi_valid, 1'b0);
    endtask

    initial begin
        logic [15:0] rd;
        logic s;
        int l_rise;

        wait_clk(5);
        chk("rst_dreq", DREQ, 1'b0);
        chk("rst_so", SO, 1'b0);
        chk("rst_reg_wr", reg_wr, 1'b0);
        chk("rst_reg_addr", reg_addr, 4'h0);
        chk("rst_reg_wdata", reg_wdata, 16'h0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_sdi_valid", sdi_valid, 1'b0);
        rst = 1'b1;

        wait_clk(HRST_CYCLES - 3);
        chk("hrst_dreq_low", DREQ, 1'b0);
        wait_clk(9);
        chk("hrst_dreq_high", DREQ, 1'b1);

        sci_read_chk("rd_mode_default", 8'h00, 16'h0800);

        XDCS = 1'b0;
        sci_write(8'h0B, 16'h1234);
        XDCS = 1'b1;
        check_wr("wr_b");
        chk("sci_wins_sdi", sdi_valid, 1'b0);
        sci_read_chk("rd_b", 8'h0B, 16'h1234);

        sci_write(8'h15, 16'hBEEF);
        check_wr("wr_oob");
        sci_read_chk("rd_oob_alias", 8'h1B, 16'h0000);
        sci_read_chk("rd_5_untouched", 8'h05, 16'h0000);

        sci_xfer({8'h02, 8'h03, 16'h7000}, 20, rd);
        check_wr("wr_abort");
        sci_read_chk("rd_abort", 8'h03, 16'h0000);
        sci_write(8'h03, 16'h7000);
        check_wr("wr_3");
        sci_read_chk("rd_3", 8'h03, 16'h7000);

        sci_xfer({8'h05, 8'h03, 16'hFFFF}, 32, rd);
        check_wr("wr_bad_op");
        sci_read_chk("rd_3_after_bad_op", 8'h03, 16'h7000);

        XDCS = 1'b0;
        wait_clk(HALF);
        for (int k = 0; k < 97; k++) begin
            sdi_byte(8'($urandom), k < FIFO_DEPTH);
            wait_clk(2);
            if (k == 31) chk("dreq_free32", DREQ, 1'b1);
            if (k == 32) chk("dreq_free31", DREQ, 1'b0);
            if (k == 63) chk("ovf_at_full", overflow, 1'b0);
        end
        XDCS = 1'b1;
        chk("ovf_set", overflow, 1'b1);
        chk("full_valid", sdi_valid, 1'b1);
        chk("dreq_full", DREQ, 1'b0);
        drain("fifo_byte");
        chk("ovf_sticky", overflow, 1'b1);
        wait_clk(2);
        chk("dreq_after_drain", DREQ, 1'b1);

        XDCS = 1'b0;
        wait_clk(HALF);
        for (int k = 0; k < 3; k++) sdi_byte(8'h50 + 8'(k), 1'b0);
        XDCS = 1'b1;
        wait_clk(4);
        chk("pre_srst_valid", sdi_valid, 1'b1);
        sci_xfer({8'h02, 8'h00, 16'h0804}, 32, rd);
        l_rise = last_rise;
        chk("srst_wr_count", wr_obs.size(), 1);
        if (wr_obs.size() > 0) chk("srst_wr_addr", {28'h0, wr_obs[0][19:16]}, 32'h0);
        wr_obs.delete();
        chk("srst_flush", sdi_valid, 1'b0);
        chk("srst_ovf_clr", overflow, 1'b0);
        chk("srst_dreq_drop", DREQ, 1'b0);
        wait_until(l_rise + SRST_CYCLES - 5);
        chk("srst_dreq_low", DREQ, 1'b0);
        wait_until(l_rise + SRST_CYCLES + 12);
        chk("srst_dreq_high", DREQ, 1'b1);
        sci_read_chk("rd_mode_after_srst", 8'h00, 16'h0800);
        sci_read_chk("rd_b_kept", 8'h0B, 16'h1234);

        XDCS = 1'b0;
        wait_clk(HALF);
        sdi_byte(8'hA5, 1'b0);
        for (int k = 0; k < 4; k++) spi_bit(1'b1, s);
        XRESET = 1'b0;
        wait_clk(10);
        chk("hard_flush", sdi_valid, 1'b0);
        chk("hard_dreq", DREQ, 1'b0);
        XDCS = 1'b1;
        XRESET = 1'b1;
        wait_clk(HRST_CYCLES - 5);
        chk("hard_dreq_low", DREQ, 1'b0);
        wait_clk(15);
        chk("hard_dreq_high", DREQ, 1'b1);
        sci_read_chk("hard_rd_b", 8'h0B, 16'h0000);
        sci_read_chk("hard_rd_3", 8'h03, 16'h0000);
        sci_read_chk("hard_rd_mode", 8'h00, 16'h0800);

        XDCS = 1'b0;
        wait_clk(HALF);
        sdi_byte(8'h3C, 1'b1);
        XDCS = 1'b1;
        wait_clk(4);
        drain("post_hard_byte");
        chk("post_hard_ovf", overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
